// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-ported memory with a ready handshake.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              wr0,
  input  logic              wr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_read,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t            state, nextState;
  logic              ownerQ;          // 0 = port 0 owns the bus, 1 = port 1
  logic              grantValid;
  logic              grantPort;
  logic [DATA_W-1:0] rdata0Q, rdata1Q;

  logic              ownReq, ownWr;
  logic [ADDR_W-1:0] ownAddr;
  logic [DATA_W-1:0] ownWdata;
  logic              issuing;
  logic              ackNow;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrant;
`endif

  // Arbitration decision, only consumed while IDLE.
  always_comb begin
    grantValid = req0 | req1;
`ifdef ARB_ROUND_ROBIN_EN
    grantPort  = (req0 && req1) ? ~lastGrant : !req0;
`else
    grantPort  = !req0;
`endif
  end

  // Owner's live request lines; the owner must hold them stable until ack.
  assign ownReq   = ownerQ ? req1   : req0;
  assign ownWr    = ownerQ ? wr1    : wr0;
  assign ownAddr  = ownerQ ? addr1  : addr0;
  assign ownWdata = ownerQ ? wdata1 : wdata0;

  // A dropped request while ISSUE aborts the access in that same cycle.
  assign issuing = (state == ISSUE) && ownReq && !rst;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    nextState = state;
    ackNow    = 1'b0;
    unique case (state)
      IDLE: begin
        if (grantValid) nextState = ISSUE;
      end
      ISSUE: begin
        if (!ownReq) begin
          nextState = IDLE;
        end else if (mem_ready) begin
          nextState = ownWr ? IDLE : RDATA;
          ackNow    = ownWr;
        end
      end
      RDATA: begin
        nextState = IDLE;
        ackNow    = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ownerQ  <= 1'b0;
      rdata0Q <= '0;
      rdata1Q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrant <= 1'b1;
`endif
    end else begin
      state <= nextState;
      if (state == IDLE && grantValid) begin
        ownerQ <= grantPort;
`ifdef ARB_ROUND_ROBIN_EN
        lastGrant <= grantPort;
`endif
      end
      if (state == RDATA) begin
        if (ownerQ) rdata1Q <= mem_read;
        else        rdata0Q <= mem_read;
      end
    end
  end

  // All outputs are forced to zero while reset is asserted, even mid-transfer.
  assign gnt0 = !rst && (state != IDLE) && !ownerQ;
  assign gnt1 = !rst && (state != IDLE) &&  ownerQ;
  assign ack0 = !rst && ackNow && !ownerQ;
  assign ack1 = !rst && ackNow &&  ownerQ;

  // Read data bypasses the register during the ack cycle, then holds.
  assign rdata0 = rst ? '0 : ((state == RDATA && !ownerQ) ? mem_read : rdata0Q);
  assign rdata1 = rst ? '0 : ((state == RDATA &&  ownerQ) ? mem_read : rdata1Q);

  assign mem_addr  = issuing ? ownAddr  : '0;
  assign mem_write = issuing ? ownWdata : '0;
  assign mem_we    = issuing &&  ownWr;
  assign mem_re    = issuing && !ownWr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a per-cycle vector table plus directed multi-cycle sequences.
// Honours ARB_ROUND_ROBIN_EN for the dual-request arbitration expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, gnt0, gnt1;
  logic [15:0] rdata0, rdata1;
  logic [31:0] mem_addr;
  logic [15:0] mem_write;
  logic        mem_we, mem_re;
  logic [15:0] mem_read;
  logic        mem_ready;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .wr0(wr0), .wr1(wr1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_we(mem_we), .mem_re(mem_re),
    .mem_read(mem_read), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        rst, req0, req1, wr0, wr1, rdy;
    logic [31:0] addr0, addr1;
    logic [15:0] wd0, wd1, mrd;
    logic        gnt0, gnt1, ack0, ack1, we, re;
    logic [31:0] mAddr;
    logic [15:0] mWrite, rd0, rd1;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic r0, input logic r1, input logic w0, input logic w1, input logic rdy);
    req0 = r0; req1 = r1; wr0 = w0; wr1 = w1; mem_ready = rdy;
    #1;
  endtask

  function automatic logic [85:0] outVec();
    return {gnt0, gnt1, ack0, ack1, mem_we, mem_re, mem_addr, mem_write, rdata0, rdata1};
  endfunction

  initial begin
    int weCnt, ackCnt, nGrant, exclBad;
    logic [3:0] grantSeq, grantExp;

    // rst, req0, req1, wr0, wr1, rdy, addr0, addr1, wd0, wd1, mrd | gnt0, gnt1, ack0, ack1, we, re, mAddr, mWrite, rd0, rd1
    vecs[0] = '{1, 1, 0, 1, 0, 1, 32'hD0000010, 0, 16'hBEEF, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 1, 0, 1, 32'hD0000010, 0, 16'hBEEF, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 1, 0, 1, 0, 1, 32'hD0000010, 0, 16'hBEEF, 0, 0,       1, 0, 1, 0, 1, 0, 32'hD0000010, 16'hBEEF, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 1, 0, 0, 1, 0, 32'h10000004, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{0, 0, 1, 0, 0, 1, 0, 32'h10000004, 0, 0, 0,              0, 1, 0, 0, 0, 1, 32'h10000004, 0, 0, 0};
    vecs[7] = '{0, 0, 1, 0, 0, 1, 0, 32'h10000004, 0, 0, 16'h1234,       0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h1234};
    vecs[8] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFF,                  0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234};

    rst = 1'b1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; mem_read = 0; mem_ready = 0;
    nextCycle();

    // Reset, port-0 write and port-1 read, one row per clock cycle.
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; req0 = vecs[i].req0; req1 = vecs[i].req1;
      wr0 = vecs[i].wr0; wr1 = vecs[i].wr1; mem_ready = vecs[i].rdy;
      addr0 = vecs[i].addr0; addr1 = vecs[i].addr1;
      wdata0 = vecs[i].wd0; wdata1 = vecs[i].wd1; mem_read = vecs[i].mrd;
      #1;
      check($sformatf("vec[%0d]", i), 128'(outVec()),
            128'({vecs[i].gnt0, vecs[i].gnt1, vecs[i].ack0, vecs[i].ack1, vecs[i].we, vecs[i].re,
                  vecs[i].mAddr, vecs[i].mWrite, vecs[i].rd0, vecs[i].rd1}));
      nextCycle();
    end

    // Memory stalls four cycles: strobe held five cycles, single ack.
    addr0 = 32'h0000_0040; wdata0 = 16'h5A5A; mem_read = 0;
    setIn(1, 0, 1, 0, 0);
    nextCycle();
    weCnt = 0; ackCnt = 0;
    for (int c = 0; c < 5; c++) begin
      setIn(1, 0, 1, 0, c == 4);
      if (mem_we) weCnt++;
      if (ack0) ackCnt++;
      if (c < 4) check($sformatf("stall_noack[%0d]", c), 128'(ack0), 128'(0));
      nextCycle();
    end
    setIn(0, 0, 0, 0, 1);
    check("stall_we_cycles", 128'(weCnt), 128'(5));
    check("stall_ack_count", 128'(ackCnt), 128'(1));
    check("stall_gnt_cleared", 128'({gnt0, gnt1}), 128'(0));
    nextCycle();

    // Port 0 aborts a stalled read; pending port 1 is then served.
    addr0 = 32'h0000_0080; addr1 = 32'h0000_0090;
    setIn(1, 0, 0, 0, 0);
    nextCycle();
    setIn(1, 1, 0, 0, 0);
    check("abort_pre_strobe", 128'({gnt0, gnt1, mem_re, ack1}), 128'(4'b1010));
    nextCycle();
    setIn(0, 1, 0, 0, 0);
    check("abort_cycle", 128'({mem_re, mem_we, ack0, ack1, mem_addr}), 128'(0));
    nextCycle();
    check("abort_idle", 128'({gnt0, gnt1, ack0}), 128'(0));
    nextCycle();
    setIn(0, 1, 0, 0, 1);
    check("abort_then_gnt1", 128'({gnt0, gnt1, mem_re, mem_addr}), 128'({3'b011, 32'h0000_0090}));
    nextCycle();
    mem_read = 16'hC0DE;
    #1;
    check("abort_then_ack1", 128'({ack0, ack1, rdata1}), 128'({2'b01, 16'hC0DE}));
    nextCycle();
    setIn(0, 0, 0, 0, 1);

    // Reset during RDATA kills the ack and clears read data; then a fresh write.
    addr0 = 32'h0000_00A0; mem_read = 16'h7777;
    setIn(1, 0, 0, 0, 1);
    nextCycle();
    check("rstmid_issue_re", 128'(mem_re), 128'(1));
    nextCycle();
    rst = 1'b1;
    #1;
    check("rstmid_outputs_zero", 128'(outVec()), 128'(0));
    nextCycle();
    rst = 1'b0;
    setIn(0, 0, 0, 0, 1);
    check("rstmid_idle_after", 128'(outVec()), 128'(0));
    nextCycle();
    wdata0 = 16'h1111;
    setIn(1, 0, 1, 0, 1);
    nextCycle();
    check("rstmid_new_write", 128'({gnt0, ack0, mem_we, mem_write}), 128'({3'b111, 16'h1111}));
    nextCycle();
    setIn(0, 0, 0, 0, 1);

    // Both ports read continuously, starting from a fresh reset.
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    setIn(1, 1, 0, 0, 1);
    grantSeq = 0; nGrant = 0; exclBad = 0;
    for (int c = 0; c < 12; c++) begin
      mem_read = 16'hA000 + 16'(c);
      #1;
      if ((ack0 && ack1) || (mem_we && mem_re)) exclBad++;
      if ((ack0 || ack1) && nGrant < 4) begin
        grantSeq[nGrant] = ack1;
        check($sformatf("dual_rdata[%0d]", nGrant), 128'(ack1 ? rdata1 : rdata0), 128'(16'hA000 + 16'(c)));
        nGrant++;
      end
      nextCycle();
    end
    setIn(0, 0, 0, 0, 1);
`ifdef ARB_ROUND_ROBIN_EN
    grantExp = 4'b1010;
`else
    grantExp = 4'b0000;
`endif
    check("dual_grant_count", 128'(nGrant), 128'(4));
    check("dual_grant_order", 128'(grantSeq), 128'(grantExp));
    check("dual_exclusive", 128'(exclBad), 128'(0));
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
